// File: rtl/wb_irq_ctrl_if.sv
// Wishbone B3 slave bus bundle for the interrupt controller register port.
interface wb_irq_ctrl_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: per-source sync, level/edge detect, polarity,
// mask and latched pending bits with W1C/SET and lowest-index priority ID.
module wb_irq_ctrl #(
  parameter int          NUM_SRC      = 8,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] DEFAULT_MODE = 32'h0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_irq_ctrl_if.slave       wb,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic               irq_any_o
);
  localparam logic [31:0] SRC_MSK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << NUM_SRC) - 32'd1);

  logic [31:0] src_raw, s, p_q;
  logic [31:0] mode_q, mode_d, pol_q, pol_d, mask_q, mask_d, pend_q, pend_d;
  logic [31:0] dat_q, dat_d, rdata, be, wmask, w1c, swset;
  logic [31:0] lvl, edg, ev, status, id;
  logic        ack_q, err_q, req, wr_ro, wr;
  logic [2:0]  reg_sel;
  logic        unused_adr;

  always_comb begin
    src_raw = '0;
    src_raw[NUM_SRC-1:0] = irq_src_i;
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src_raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][31:0] sync_q;
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= src_raw;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edges are taken on the pre-polarity signal so a POL write cannot fake one.
  assign lvl = s ^ pol_q;
  assign edg = (s & ~p_q & ~pol_q) | (~s & p_q & pol_q);
  assign ev  = ((mode_q & edg) | (~mode_q & lvl)) & SRC_MSK;

  assign status = pend_q & mask_q;

  always_comb begin
    id = '0;
    for (int k = 31; k >= 0; k--)
      if (status[k]) id = {1'b1, 26'd0, 5'(k)};
  end

  // One access per ack: a request is ignored while ack/err is still high.
  assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
  assign reg_sel    = wb.wb_adr_i[4:2];
  assign unused_adr = ^wb.wb_adr_i[1:0];
  assign wr_ro      = (reg_sel == 3'd0) || (reg_sel == 3'd5) || (reg_sel == 3'd7);
  assign wr         = req & wb.wb_we_i & ~wr_ro;
  assign be         = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                       {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  assign wmask      = wb.wb_dat_i & be;

  always_comb begin
    mode_d = mode_q;
    pol_d  = pol_q;
    mask_d = mask_q;
    w1c    = '0;
    swset  = '0;
    if (wr) begin
      case (reg_sel)
        3'd1:    mode_d = ((mode_q & ~be) | wmask) & SRC_MSK;
        3'd2:    pol_d  = ((pol_q  & ~be) | wmask) & SRC_MSK;
        3'd3:    mask_d = ((mask_q & ~be) | wmask) & SRC_MSK;
        3'd4:    w1c    = wmask;
        3'd6:    swset  = wmask;
        default: ;
      endcase
    end
    pend_d = ((pend_q & ~w1c) | ev | swset) & SRC_MSK;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata = s & SRC_MSK;
      3'd1:    rdata = mode_q;
      3'd2:    rdata = pol_q;
      3'd3:    rdata = mask_q;
      3'd4:    rdata = pend_q;
      3'd5:    rdata = status;
      3'd7:    rdata = id;
      default: rdata = '0;
    endcase
    dat_d = (req & ~wb.wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      p_q    <= '0;
      mode_q <= DEFAULT_MODE & SRC_MSK;
      pol_q  <= '0;
      mask_q <= '0;
      pend_q <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      p_q    <= s;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      dat_q  <= dat_d;
      ack_q  <= req & ~(wb.wb_we_i & wr_ro);
      err_q  <= req & wb.wb_we_i & wr_ro;
    end
  end

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign irq_o       = status[NUM_SRC-1:0];
  assign irq_any_o   = |status;
endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed bench: an 8-source and a 12-source controller share one bus stimulus.
module tb_wb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src = '0;
  logic [7:0]  irq8;
  logic [11:0] irq12;
  logic        any8, any12;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wb_irq_ctrl_if b8();
  wb_irq_ctrl_if b12();

  assign b12.wb_adr_i = b8.wb_adr_i;
  assign b12.wb_dat_i = b8.wb_dat_i;
  assign b12.wb_sel_i = b8.wb_sel_i;
  assign b12.wb_we_i  = b8.wb_we_i;
  assign b12.wb_cyc_i = b8.wb_cyc_i;
  assign b12.wb_stb_i = b8.wb_stb_i;

  wb_irq_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2), .DEFAULT_MODE(32'h0)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(b8),
    .irq_src_i(src), .irq_o(irq8), .irq_any_o(any8));

  wb_irq_ctrl #(.NUM_SRC(12), .SYNC_STAGES(2), .DEFAULT_MODE(32'hFFFF_F0F0)) dut12 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(b12),
    .irq_src_i({4'b0, src}), .irq_o(irq12), .irq_any_o(any12));

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    logic        eerr;
    logic        c12;
    logic [31:0] exp12;
  } vec_t;

  vec_t rst_tbl[$];
  vec_t set_tbl[$];
  vec_t be_tbl[$];

  function automatic vec_t mk(logic we, logic [4:0] adr, logic [31:0] dat, logic [3:0] sel,
                              logic [31:0] exp, logic eerr, logic c12, logic [31:0] exp12);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.exp = exp; v.eerr = eerr; v.c12 = c12; v.exp12 = exp12;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts right after a clock edge; returns 1ns after the ack/err edge.
  task automatic xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd8, output logic e8,
                      output logic [31:0] rd12, output logic e12);
    int n;
    b8.wb_we_i = we; b8.wb_adr_i = adr; b8.wb_dat_i = dat; b8.wb_sel_i = sel;
    b8.wb_cyc_i = 1'b1; b8.wb_stb_i = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!(b8.wb_ack_o || b8.wb_err_o) && n < 8);
    if (!(b8.wb_ack_o || b8.wb_err_o)) begin
      n_chk++;
      n_fail++;
      $display("FAIL bus_timeout: no ack/err at adr %h", adr);
    end
    rd8 = b8.wb_dat_o; e8 = b8.wb_err_o; rd12 = b12.wb_dat_o; e12 = b12.wb_err_o;
    b8.wb_cyc_i = 1'b0; b8.wb_stb_i = 1'b0; b8.wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat);
    logic [31:0] r8, r12;
    logic e8, e12;
    xfer(1'b1, adr, dat, 4'hF, r8, e8, r12, e12);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] r8, r12;
    logic e8, e12;
    xfer(1'b0, adr, 32'h0, 4'hF, r8, e8, r12, e12);
    chk(nm, r8, exp);
  endtask

  task automatic run(input string nm, input vec_t v);
    logic [31:0] r8, r12;
    logic e8, e12;
    xfer(v.we, v.adr, v.dat, v.sel, r8, e8, r12, e12);
    chk({nm, "_dat"}, r8, v.exp);
    chk({nm, "_err"}, 32'(e8), 32'(v.eerr));
    if (v.c12) begin
      chk({nm, "_dat12"}, r12, v.exp12);
      chk({nm, "_err12"}, 32'(e12), 32'(v.eerr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 8; a++)
      rst_tbl.push_back(mk(1'b0, 5'(a * 4), 32'h0, 4'hF, 32'h0, 1'b0, 1'b1,
                           (a == 1) ? 32'h0000_00F0 : 32'h0));

    set_tbl.push_back(mk(1'b1, 5'h0C, 32'h0000_0080, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b1, 5'h10, 32'h0000_00FF, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b1, 5'h18, 32'h0000_0081, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b0, 5'h10, 32'h0, 4'hF, 32'h0000_0081, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b0, 5'h14, 32'h0, 4'hF, 32'h0000_0080, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b0, 5'h1C, 32'h0, 4'hF, 32'h8000_0007, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b1, 5'h1C, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b0, 5'h1C, 32'h0, 4'hF, 32'h8000_0007, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b1, 5'h00, 32'hFF, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b1, 5'h14, 32'hFF, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b0, 5'h04, 32'h0, 4'hF, 32'h0000_0024, 1'b0, 1'b0, 32'h0));
    set_tbl.push_back(mk(1'b0, 5'h00, 32'h0, 4'hF, 32'h0000_0004, 1'b0, 1'b0, 32'h0));

    be_tbl.push_back(mk(1'b1, 5'h0C, 32'hFFFF_FFFF, 4'b0001, 32'h0, 1'b0, 1'b1, 32'h0));
    be_tbl.push_back(mk(1'b0, 5'h0C, 32'h0, 4'hF, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_00FF));
    be_tbl.push_back(mk(1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0));
    be_tbl.push_back(mk(1'b0, 5'h0C, 32'h0, 4'hF, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_0FFF));
    be_tbl.push_back(mk(1'b1, 5'h0C, 32'h0, 4'b0010, 32'h0, 1'b0, 1'b1, 32'h0));
    be_tbl.push_back(mk(1'b0, 5'h0C, 32'h0, 4'hF, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_00FF));

    b8.wb_adr_i = '0; b8.wb_dat_i = '0; b8.wb_sel_i = '0;
    b8.wb_we_i = 1'b0; b8.wb_cyc_i = 1'b0; b8.wb_stb_i = 1'b0;

    tick(3);
    chk("rst_irq", 32'(irq8), 32'h0);
    chk("rst_ack", 32'(b8.wb_ack_o), 32'h0);
    rst = 1'b0;
    tick(1);

    foreach (rst_tbl[i]) begin
      run($sformatf("rst_rd%0d", i), rst_tbl[i]);
      tick(1);
      chk($sformatf("ack_width%0d", i), 32'(b8.wb_ack_o), 32'h0);
    end
    chk("rst_irq_any", 32'(any8), 32'h0);

    // Level latch with three-cycle latency
    wr(5'h0C, 32'hFF);
    tick(1);
    src[3] = 1'b1;
    tick(2);
    chk("lvl_cyc2", 32'(irq8), 32'h00);
    tick(1);
    chk("lvl_cyc3", 32'(irq8), 32'h08);
    wr(5'h10, 32'h08);
    rd_chk("lvl_w1c_held", 5'h10, 32'h08);
    src[3] = 1'b0;
    tick(4);
    wr(5'h10, 32'h08);
    rd_chk("lvl_w1c_drop", 5'h10, 32'h00);

    // Falling-edge detection and POL toggling
    wr(5'h04, 32'h20);
    wr(5'h08, 32'h20);
    rd_chk("edge_no_spur", 5'h10, 32'h00);
    src[5] = 1'b1;
    tick(3);
    rd_chk("edge_rise_ign", 5'h10, 32'h00);
    src[5] = 1'b0;
    tick(5);
    rd_chk("edge_fall", 5'h10, 32'h20);
    chk("edge_irq", 32'(irq8), 32'h20);
    wr(5'h10, 32'h20);
    rd_chk("edge_w1c", 5'h10, 32'h00);
    wr(5'h08, 32'h00);
    wr(5'h08, 32'h20);
    tick(3);
    rd_chk("pol_toggle", 5'h10, 32'h00);

    // Edge on bit 2 lands on the same edge that commits its W1C
    wr(5'h04, 32'h24);
    tick(1);
    src[2] = 1'b1;
    tick(2);
    wr(5'h10, 32'h04);
    rd_chk("race_set_wins", 5'h10, 32'h04);
    wr(5'h10, 32'h04);
    rd_chk("race_clear", 5'h10, 32'h00);

    foreach (set_tbl[i]) run($sformatf("set%0d", i), set_tbl[i]);
    chk("set_irq", 32'(irq8), 32'h80);
    chk("set_irq_any", 32'(any8), 32'h1);

    foreach (be_tbl[i]) run($sformatf("be%0d", i), be_tbl[i]);

    // Reset landing on a write request drops the ack
    tick(1);
    b8.wb_we_i = 1'b1; b8.wb_adr_i = 5'h08; b8.wb_dat_i = 32'hFF; b8.wb_sel_i = 4'hF;
    b8.wb_cyc_i = 1'b1; b8.wb_stb_i = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("rst_mid_ack", 32'(b8.wb_ack_o), 32'h0);
    chk("rst_mid_irq", 32'(irq8), 32'h0);
    b8.wb_cyc_i = 1'b0; b8.wb_stb_i = 1'b0; b8.wb_we_i = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    rd_chk("rst_mid_pol", 5'h08, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
